// File: rtl/writeback_queue_pkg.sv
// Shared register-file constants and the queue entry type for the writeback queue.
package writeback_queue_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_fwd_match.sv
// wb_fwd_match: picks the youngest valid entry whose address matches the lookup.
// Inputs arrive in age order, so slot 0 is the head and higher slots are younger.
module wb_fwd_match
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]                 vld_i,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_i,
    input  logic [DEPTH-1:0][REG_DATA_W-1:0] data_i,
    input  logic [REG_ADDR_W-1:0]            lookup_i,
    output logic                             hit_o,
    output logic [REG_DATA_W-1:0]            data_o
);

    // Ascending scan: a later (younger) match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_i[k] && (addr_i[k] == lookup_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[k];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Two-source writeback queue feeding a single register-file write port.
// Define WB_FORWARD_EN to enable operand forwarding lookups into pending entries.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        alu_valid,
    input  logic [REG_ADDR_W-1:0]       alu_addr,
    input  logic [REG_DATA_W-1:0]       alu_data,
    output logic                        alu_ready,
    input  logic                        mem_valid,
    input  logic [REG_ADDR_W-1:0]       mem_addr,
    input  logic [REG_DATA_W-1:0]       mem_data,
    output logic                        mem_ready,
    input  logic                        wb_hold,
    output logic                        wb_en,
    output logic [REG_ADDR_W-1:0]       wb_addr,
    output logic [REG_DATA_W-1:0]       wb_data,
    input  logic [REG_ADDR_W-1:0]       fwd_a_addr,
    output logic                        fwd_a_hit,
    output logic [REG_DATA_W-1:0]       fwd_a_data,
    input  logic [REG_ADDR_W-1:0]       fwd_b_addr,
    output logic                        fwd_b_hit,
    output logic [REG_DATA_W-1:0]       fwd_b_data,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M2_C = CW'(DEPTH - 2);

    wb_entry_t       entries_q [DEPTH];
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            mem_acc, alu_acc, deq;
    logic [AW-1:0]   wr_idx, alu_idx, rd_idx;
    wb_entry_t       head;

    // Ready looks only at registered occupancy; a dequeue in the same cycle earns no credit.
    assign mem_ready = (count_q < DEPTH_C);
    assign alu_ready = mem_valid ? (count_q <= DEPTH_M2_C) : (count_q < DEPTH_C);

    assign mem_acc = mem_valid & mem_ready;
    assign alu_acc = alu_valid & alu_ready;
    assign deq     = wb_en & ~wb_hold;

    // Load takes the first free slot so it is older than a same-cycle ALU result.
    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign alu_idx = wr_idx + AW'(mem_acc);
    assign rd_idx  = rd_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q + CW'(mem_acc) + CW'(alu_acc);
        rd_ptr_d = rd_ptr_q + CW'(deq);
        count_d  = count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy comes from the pointers alone.
    always_ff @(posedge clock) begin
        if (mem_acc) entries_q[wr_idx]  <= '{addr: mem_addr, data: mem_data};
        if (alu_acc) entries_q[alu_idx] <= '{addr: alu_addr, data: alu_data};
    end

    assign head    = entries_q[rd_idx];
    assign wb_en   = (count_q != '0);
    assign wb_addr = wb_en ? head.addr : '0;
    assign wb_data = wb_en ? head.data : '0;
    assign count   = count_q;

`ifdef WB_FORWARD_EN
    logic [DEPTH-1:0]                 age_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] age_addr;
    logic [DEPTH-1:0][REG_DATA_W-1:0] age_data;

    // Rotate storage into age order so the matcher can resolve youngest-wins by slot index.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [AW-1:0] slot;
        assign slot        = rd_idx + AW'(k);
        assign age_vld[k]  = (CW'(k) < count_q);
        assign age_addr[k] = entries_q[slot].addr;
        assign age_data[k] = entries_q[slot].data;
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .vld_i    (age_vld),
        .addr_i   (age_addr),
        .data_i   (age_data),
        .lookup_i (fwd_a_addr),
        .hit_o    (fwd_a_hit),
        .data_o   (fwd_a_data)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .vld_i    (age_vld),
        .addr_i   (age_addr),
        .data_i   (age_data),
        .lookup_i (fwd_b_addr),
        .hit_o    (fwd_b_hit),
        .data_o   (fwd_b_data)
    );
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_a_addr, fwd_b_addr};
    assign fwd_a_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH=4).
module tb_writeback_queue;

    localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, mem_valid, wb_hold;
    logic [3:0]  alu_addr, mem_addr, fwd_a_addr, fwd_b_addr;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, wb_en, fwd_a_hit, fwd_b_hit;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data, fwd_a_data, fwd_b_data;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int wr_snap;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_hold(wb_hold), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_a_addr(fwd_a_addr), .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_addr(fwd_b_addr), .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
        .count(count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (wb_en && !wb_hold) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; alu_valid = 0; mem_valid = 0; wb_hold = 0;
        alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0;
        fwd_a_addr = 0; fwd_b_addr = 0;
        #2;
        chk("rst_wb_en", wb_en, 0);
        chk("rst_count", count, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_fwd_a_hit", fwd_a_hit, 0);
        chk("rst_fwd_b_hit", fwd_b_hit, 0);
        tick();
        reset_n = 1'b1;

        // Single ALU write with one-cycle latency, then drained.
        alu_valid = 1; alu_addr = 4'd3; alu_data = 16'h1234;
        tick();
        alu_valid = 0;
        chk("t1_wb_en", wb_en, 1);
        chk("t1_wb_addr", wb_addr, 3);
        chk("t1_wb_data", wb_data, 16'h1234);
        chk("t1_count", count, 1);
        tick();
        chk("t1_count_drained", count, 0);
        chk("t1_wb_en_drained", wb_en, 0);

        // Both sources to the same register, held: load must be older.
        wb_hold = 1;
        mem_valid = 1; mem_addr = 4'd5; mem_data = 16'hAAAA;
        alu_valid = 1; alu_addr = 4'd5; alu_data = 16'hBBBB;
        #1;
        chk("t2_alu_ready", alu_ready, 1);
        tick();
        mem_valid = 0; alu_valid = 0;
        fwd_a_addr = 4'd5; fwd_b_addr = 4'd7;
        #1;
        chk("t2_count", count, 2);
        chk("t2_fwd_a_hit", fwd_a_hit, FWD_EN);
        chk("t2_fwd_a_data", fwd_a_data, FWD_EN ? 16'hBBBB : 16'h0);
        chk("t2_fwd_b_hit", fwd_b_hit, 0);
        chk("t2_head_data", wb_data, 16'hAAAA);
        wb_hold = 0;
        tick();
        chk("t2_second_data", wb_data, 16'hBBBB);
        chk("t2_count1", count, 1);
        tick();
        chk("t2_count0", count, 0);

        // Fill to DEPTH, then hold a fifth request that must be refused.
        wb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_addr = 4'd1; alu_data = 16'h1000 + 16'(i);
            tick();
        end
        chk("t3_count_full", count, 4);
        chk("t3_alu_ready_full", alu_ready, 0);
        chk("t3_mem_ready_full", mem_ready, 0);
        alu_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_count_held", count, 4);
        end
        alu_valid = 0;
        chk("t3_head", wb_data, 16'h1000);
        wb_hold = 0;
        tick();
        chk("t3_count3", count, 3);

        // count=3: load wins the last slot, ALU refused.
        wb_hold = 1;
        mem_valid = 1; mem_addr = 4'd9;  mem_data = 16'h9999;
        alu_valid = 1; alu_addr = 4'hA;  alu_data = 16'hAAAA;
        #1;
        chk("t4_mem_ready", mem_ready, 1);
        chk("t4_alu_ready", alu_ready, 0);
        tick();
        mem_valid = 0; alu_valid = 0;
        fwd_a_addr = 4'd9; fwd_b_addr = 4'd1;
        #1;
        chk("t4_count", count, 4);
        chk("t4_fwd_a_data", fwd_a_data, FWD_EN ? 16'h9999 : 16'h0);
        chk("t4_fwd_b_data", fwd_b_data, FWD_EN ? 16'h1003 : 16'h0);
        fwd_b_addr = 4'hA;
        #1;
        chk("t4_fwd_b_alu_dropped", fwd_b_hit, 0);
        wb_hold = 0;
        chk("t4_drain0", wb_data, 16'h1001); tick();
        chk("t4_drain1", wb_data, 16'h1002); tick();
        chk("t4_drain2", wb_data, 16'h1003); tick();
        chk("t4_drain3", wb_data, 16'h9999); tick();
        chk("t4_empty", count, 0);

        // count=2: two enqueues and one dequeue on the same edge, then pointer wrap.
        wb_hold = 1;
        alu_valid = 1; alu_addr = 4'd2; alu_data = 16'h2001; tick();
        alu_data = 16'h2002; tick();
        alu_valid = 0;
        chk("t5_count2", count, 2);
        wb_hold = 0;
        mem_valid = 1; mem_addr = 4'd6; mem_data = 16'h6006;
        alu_valid = 1; alu_addr = 4'd7; alu_data = 16'h7007;
        tick();
        mem_valid = 0;
        chk("t5_count3", count, 3);
        chk("t5_head", wb_data, 16'h2002);
        for (int i = 0; i < 10; i++) begin
            logic [15:0] exp_head;
            alu_data = 16'h3000 + 16'(i);
            exp_head = (i == 0) ? 16'h2002 : (i == 1) ? 16'h6006 : (i == 2) ? 16'h7007
                                                                          : 16'h3000 + 16'(i - 3);
            chk("t5_wrap_head", wb_data, exp_head);
            tick();
        end
        alu_valid = 0;
        chk("t5_wrap_count", count, 3);
        chk("t5_wrap_tail_head", wb_data, 16'h3007);

        // Asynchronous reset mid-cycle with entries pending.
        wb_hold = 1;
        tick();
        chk("t6_count3", count, 3);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_wb_en_async", wb_en, 0);
        chk("t6_count_async", count, 0);
        chk("t6_wb_addr_async", wb_addr, 0);
        wr_snap = wr_cnt;
        wb_hold = 0;
        #1 reset_n = 1'b1;
        tick();
        chk("t6_no_write_count", count, 0);
        chk("t6_no_write_en", wb_en, 0);
        chk("t6_no_write_strobe", wr_cnt, wr_snap);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
